pci_mem_target: RTL

Parametrised PCI target with a burst-capable register file. It claims a configurable window of dword addresses on the shared 32-bit AD bus and serves single and linear-burst memory read/write transactions. It supports selectable DEVSEL timing, initial wait states, active-low byte enables, and target disconnect (STOP#) at the window end. It replaces the fixed three-register target and sits directly on the PCI bus beside other targets.

---
 rtl/pci_pkg.sv | 25 ++
 rtl/pci_reg_file.sv | 39 +++
 rtl/pci_mem_target.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI memory target: bus command codes,
// DEVSEL timing selections, FSM state encoding and a pointer-width helper.
package pci_pkg;

  localparam logic [3:0] CMD_MEM_READ  = 4'b0010;
  localparam logic [3:0] CMD_MEM_WRITE = 4'b0011;

  localparam int DEVSEL_FAST = 0;
  localparam int DEVSEL_MED  = 1;
  localparam int DEVSEL_SLOW = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DATA,
    ST_DISC,
    ST_TURN
  } pci_state_e;

  // A single-register window still needs a one-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pci_reg_file.sv
// NUM_REGS x 32 register file: one byte-laned write port, one combinational
// read port, cleared asynchronously by the active-low reset.
module pci_reg_file
  import pci_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int PW       = ptr_width(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] i_waddr,
  input  logic [3:0]    i_wbe,
  input  logic [31:0]   i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [NUM_REGS];
  logic        w_raddr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Lookahead reads past the last register return zero instead of X.
  assign w_raddr_ok = ({{(32-PW){1'b0}}, i_raddr} < 32'(NUM_REGS));
  assign o_rdata    = w_raddr_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/pci_mem_target.sv
// PCI memory target: claims a dword window on AD and serves single and
// linear-burst memory reads/writes, disconnecting at the window end.
module pci_mem_target
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0300,
  parameter int          NUM_REGS    = 4,
  parameter int          DEVSEL_DLY  = DEVSEL_MED,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] ad,
  input  logic [3:0]  cbe,
  input  logic        frame,
  input  logic        irdy,
  output logic        trdy,
  output logic        devsel,
  output logic        stop
);

  localparam int              PW            = ptr_width(NUM_REGS);
  localparam int              DEV_EDGE      = 1 + DEVSEL_DLY;
  localparam int              RD_DRIVE_EDGE = (DEV_EDGE > 2) ? DEV_EDGE : 2;
  localparam logic [3:0]      DEV_OFS       = 4'(DEV_EDGE);
  localparam logic [3:0]      RD_DRV_OFS    = 4'(RD_DRIVE_EDGE);
  localparam logic [3:0]      WR_TRDY_OFS   = 4'(DEV_EDGE + WAIT_STATES);
  localparam logic [3:0]      RD_TRDY_OFS   = 4'(RD_DRIVE_EDGE + WAIT_STATES);
  localparam logic [PW-1:0]   LAST_PTR      = PW'(NUM_REGS - 1);

  pci_state_e    r_state;
  logic          r_frame_prev;
  logic          r_is_read;
  logic [PW-1:0] r_ptr;
  logic [3:0]    r_cnt;
  logic          r_trdy_n;
  logic          r_devsel_n;
  logic          r_stop_n;
  logic          r_ad_oe;
  logic [31:0]   r_ad_out;

  pci_state_e    w_state_next;
  logic          w_is_read_next;
  logic [PW-1:0] w_ptr_next;
  logic [3:0]    w_cnt_next;
  logic          w_trdy_next;
  logic          w_devsel_next;
  logic          w_stop_next;
  logic          w_ad_oe_next;
  logic          w_we;
  logic [3:0]    w_lane_we;
  logic [31:0]   w_addr_ofs;
  logic          w_in_window;
  logic          w_cmd_ok;
  logic [3:0]    w_ofs;
  logic          w_xfer;
  logic [31:0]   w_rd_data;

  assign w_addr_ofs  = ad - BASE_ADDR;
  assign w_in_window = (ad >= BASE_ADDR) && (w_addr_ofs < 32'(NUM_REGS));
  assign w_cmd_ok    = (cbe == CMD_MEM_READ) || (cbe == CMD_MEM_WRITE);
  assign w_ofs       = r_cnt + 4'd1;
  assign w_xfer      = (r_state == ST_DATA) && !irdy && !r_trdy_n;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_we[gi] = w_we & ~cbe[gi];
    end
  endgenerate

  pci_reg_file #(
    .NUM_REGS (NUM_REGS),
    .PW       (PW)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .i_waddr (r_ptr),
    .i_wbe   (w_lane_we),
    .i_wdata (ad),
    .i_raddr (w_ptr_next),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_frame_prev <= 1'b0;
      r_is_read    <= 1'b0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_trdy_n     <= 1'b1;
      r_devsel_n   <= 1'b1;
      r_stop_n     <= 1'b1;
      r_ad_oe      <= 1'b0;
      r_ad_out     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_frame_prev <= frame;
      r_is_read    <= w_is_read_next;
      r_ptr        <= w_ptr_next;
      r_cnt        <= w_cnt_next;
      r_trdy_n     <= w_trdy_next;
      r_devsel_n   <= w_devsel_next;
      r_stop_n     <= w_stop_next;
      r_ad_oe      <= w_ad_oe_next;
      // Tracks the next pointer so the following dword is on AD right after a transfer.
      r_ad_out     <= w_rd_data;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_is_read_next = r_is_read;
    w_ptr_next     = r_ptr;
    w_cnt_next     = r_cnt;
    w_trdy_next    = r_trdy_n;
    w_devsel_next  = r_devsel_n;
    w_stop_next    = r_stop_n;
    w_ad_oe_next   = r_ad_oe;
    w_we           = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
        if (r_frame_prev && !frame && w_cmd_ok && w_in_window) begin
          w_state_next   = ST_DECODE;
          w_is_read_next = (cbe == CMD_MEM_READ);
          w_ptr_next     = w_addr_ofs[PW-1:0];
          w_cnt_next     = '0;
        end
      end
      ST_DECODE: begin
        if (frame && irdy) begin
          w_state_next = ST_TURN;
          {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
        end else begin
          // r_cnt+1 is the number of the edge being taken, counted from the address edge.
          w_cnt_next = w_ofs;
          if (w_ofs >= DEV_OFS) begin
            w_devsel_next = 1'b0;
          end
          if (r_is_read && (w_ofs >= RD_DRV_OFS)) begin
            w_ad_oe_next = 1'b1;
          end
          if (w_ofs == (r_is_read ? RD_TRDY_OFS : WR_TRDY_OFS)) begin
            w_trdy_next  = 1'b0;
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_xfer) begin
          w_we = !r_is_read;
          if (frame) begin
            w_state_next = ST_TURN;
            {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
          end else if (r_ptr == LAST_PTR) begin
            w_state_next = ST_DISC;
            {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1000;
          end else begin
            w_ptr_next = r_ptr + 1'b1;
          end
        end else if (frame && irdy) begin
          w_state_next = ST_TURN;
          {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
        end
      end
      ST_DISC: begin
        if (frame) begin
          w_state_next = ST_TURN;
          {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
        end
      end
      ST_TURN: begin
        w_state_next = ST_IDLE;
        {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
      end
      default: begin
        w_state_next = ST_IDLE;
        {w_trdy_next, w_devsel_next, w_stop_next, w_ad_oe_next} = 4'b1110;
      end
    endcase
  end

  assign trdy   = r_trdy_n;
  assign devsel = r_devsel_n;
  assign stop   = r_stop_n;
  assign ad     = r_ad_oe ? r_ad_out : 32'hzzzz_zzzz;

endmodule
